cdc_in_arbiter: RTL and testbench
=================================

Name: cdc_in_arbiter

Overview:
- Shares the single USB CDC IN byte stream (in_data/in_valid/in_ready) between NUM_SRC byte-stream requesters, e.g. arcade input event encoder, status reporter, echo path.
- Grants one source at a time and holds the grant for a whole message.
- Releases on the message's last byte, a burst limit, or an idle timeout timed by USB frame beats.
- Sits between the device-side producers and the USB_CDC core.

Parameters:
- NUM_SRC, 4: number of requesters, 2..8.
- MAX_BURST, 16: max bytes accepted per grant before forced release, 1..255.
- TIMEOUT_MS, 3: frame beats (~1 ms each) with granted source not valid before forced release, 1..15.

Ports:
- clk_i  input  1  system clock (USB CDC clock domain).
- rst_i  input  1  synchronous reset, active-high.
- src_data_i  input  NUM_SRC*8  source bytes; source k on bits [8k+7:8k].
- src_valid_i  input  NUM_SRC  per-source byte valid.
- src_last_i  input  NUM_SRC  per-source end-of-message, qualified by valid.
- src_ready_o  output  NUM_SRC  per-source ready.
- frame_i  input  11  USB frame number from USB_CDC.
- usb_configured_i  input  1  host has configured the device.
- in_data_o  output  8  byte to USB_CDC IN.
- in_valid_o  output  1  byte valid to USB_CDC.
- in_ready_i  input  1  USB_CDC accepts byte.
- grant_o  output  NUM_SRC  one-hot current grant; 0 when idle.
- busy_o  output  1  high in GRANT state.

Behaviour:
- Beat: beat_1ms registered each cycle as (frame_i[0] != previous frame_i[0]). Reset clears both.
- Reset values:
  - state = IDLE; grant_o = 0; busy_o = 0.
  - in_valid_o = 0; in_data_o = 0; src_ready_o = 0.
  - rr_last = NUM_SRC-1, so source 0 has first priority.
  - burst_cnt = 0; idle_cnt = 0.
- IDLE:
  - If usb_configured_i and any src_valid_i: pick the first valid source searching rr_last+1, rr_last+2, ... with wrap modulo NUM_SRC.
  - Register grant; go to GRANT next cycle; clear burst_cnt and idle_cnt.
  - No data passes in IDLE. Arbitration latency is exactly 1 cycle.
- GRANT (source g):
  - in_data_o and in_valid_o are combinational muxes of source g.
  - src_ready_o[g] = in_ready_i; all other ready bits are 0.
  - Transfer = in_valid_o & in_ready_i; each transfer increments burst_cnt.
  - Any cycle with src_valid_i[g] clears idle_cnt. Otherwise beat_1ms increments idle_cnt.
- Release to IDLE on the cycle after any of:
  - (a) a transfer with src_last_i[g];
  - (b) a transfer making burst_cnt == MAX_BURST;
  - (c) idle_cnt reaching TIMEOUT_MS;
  - (d) usb_configured_i low.
- On release: rr_last = g; grant_o = 0. A new grant is issued no earlier than the following cycle, giving a 1 idle cycle gap per message.
- Simultaneous last and burst-limit: single release, no double effect.
- Bytes are never dropped or duplicated: a byte is consumed only on src_valid & src_ready.
- usb_configured_i low in any state: in_valid_o = 0 combinationally, all src_ready_o = 0. Sources stall and no data is discarded.
- Reset mid-message: immediate return to reset values; partial message is the source's problem.
- Counter widths:
  - burst_cnt is 8 bits.
  - idle_cnt is 4 bits and saturates at TIMEOUT_MS.
  - Grant index is $clog2(NUM_SRC) bits and wraps from NUM_SRC-1 to 0.

Optional Feature:
- Macro: CDC_ARB_FIXED_PRIO_EN.
- Defined: IDLE selection ignores rr_last; the lowest-index valid source always wins. rr_last is still updated but unused.
- Undefined: round-robin as described above.

Test Plan:
- Single source 1 sends 3 bytes 0x41,0x42,0x43 (last on 3rd), in_ready_i=1 → grant_o=4'b0010 one cycle after valid, 3 transfers in 3 consecutive cycles, grant_o=0 the cycle after the 3rd.
- Sources 0 and 2 both valid continuously with 2-byte messages → grant order 0,2,0,2; each message's bytes contiguous on in_data_o, never interleaved.
- Source 3 streams 40 bytes with no last, MAX_BURST=16 and source 0 also waiting → source 3 releases after 16 bytes, source 0 is granted next, then source 3 resumes.
- Granted source 1 drops valid mid-message → after 3 frame_i[0] toggles it is released; a waiting source 2 is then granted.
- usb_configured_i=0 with valids high → in_valid_o=0, src_ready_o=0, grant_o=0. Raise it → source 0 is granted first.
- in_ready_i toggling 1,0,1,0 during a 4-byte message → each byte appears exactly once on in_data_o, and in_data_o is stable while valid and not ready.

Source files
------------

// File: rtl/cdc_in_arbiter.sv
// Shares the USB CDC IN byte stream between NUM_SRC requesters, one whole message per grant.
// Build option: define CDC_ARB_FIXED_PRIO_EN for lowest-index-wins selection instead of round-robin.
//
// state    | meaning
// ST_IDLE  | no grant; pick the next valid source when the device is configured
// ST_GRANT | source gidx_q owns the IN stream until last byte, burst limit, timeout or deconfigure
module cdc_in_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int MAX_BURST  = 16,
   parameter int TIMEOUT_MS = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_SRC*8-1:0] src_data_i,
   input  logic [NUM_SRC-1:0]   src_valid_i,
   input  logic [NUM_SRC-1:0]   src_last_i,
   output logic [NUM_SRC-1:0]   src_ready_o,
   input  logic [10:0]          frame_i,
   input  logic                 usb_configured_i,
   output logic [7:0]           in_data_o,
   output logic                 in_valid_o,
   input  logic                 in_ready_i,
   output logic [NUM_SRC-1:0]   grant_o,
   output logic                 busy_o
);

   localparam int IW = $clog2(NUM_SRC);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t             state_q;
   logic [NUM_SRC-1:0] grant_q;
   logic [IW-1:0]      gidx_q;
   logic [IW-1:0]      rr_last_q;
   logic [7:0]         burst_q;
   logic [7:0]         burst_d;
   logic [3:0]         idle_q;
   logic [3:0]         idle_d;
   logic               frame0_q;
   logic               beat_q;
   logic [IW-1:0]      sel_idx;
   logic               sel_found;
   logic               g_valid;
   logic               g_last;
   logic               xfer;
   logic               release_c;
   logic               unused_frame;

   assign unused_frame = ^frame_i[10:1];
   assign grant_o      = grant_q;
   assign busy_o       = (state_q == ST_GRANT);
   assign g_valid      = src_valid_i[gidx_q];
   assign g_last       = src_last_i[gidx_q];
   assign xfer         = in_valid_o & in_ready_i;

   always_comb begin
      in_data_o   = '0;
      in_valid_o  = 1'b0;
      src_ready_o = '0;
      if (state_q == ST_GRANT) begin
         in_data_o           = src_data_i[{gidx_q, 3'b000} +: 8];
         in_valid_o          = g_valid & usb_configured_i;
         src_ready_o[gidx_q] = in_ready_i & usb_configured_i;
      end
   end

`ifdef CDC_ARB_FIXED_PRIO_EN
   logic unused_rr;
   assign unused_rr = ^rr_last_q;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_valid_i[i]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end
`else
   // Search starts just after the last released source so every requester gets a turn.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (!sel_found && src_valid_i[(int'(rr_last_q) + i) % NUM_SRC]) begin
            sel_found = 1'b1;
            sel_idx   = IW'((int'(rr_last_q) + i) % NUM_SRC);
         end
      end
   end
`endif

   always_comb begin
      burst_d = burst_q + {7'd0, xfer};
      idle_d  = idle_q;
      if (g_valid) begin
         idle_d = '0;
      end else if (beat_q && idle_q != 4'(TIMEOUT_MS)) begin
         idle_d = idle_q + 4'd1;
      end
      release_c = !usb_configured_i
               || (xfer && g_last)
               || (xfer && burst_d == 8'(MAX_BURST))
               || (idle_d == 4'(TIMEOUT_MS));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_last_q <= IW'(NUM_SRC - 1);
         burst_q   <= '0;
         idle_q    <= '0;
         frame0_q  <= 1'b0;
         beat_q    <= 1'b0;
      end else begin
         frame0_q <= frame_i[0];
         beat_q   <= frame_i[0] ^ frame0_q;
         case (state_q)
            ST_IDLE: begin
               if (usb_configured_i && sel_found) begin
                  state_q <= ST_GRANT;
                  gidx_q  <= sel_idx;
                  grant_q <= NUM_SRC'(1) << sel_idx;
                  burst_q <= '0;
                  idle_q  <= '0;
               end
            end
            ST_GRANT: begin
               burst_q <= burst_d;
               idle_q  <= idle_d;
               if (release_c) begin
                  state_q   <= ST_IDLE;
                  grant_q   <= '0;
                  rr_last_q <= gidx_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Directed bench for cdc_in_arbiter: per-cycle vector table plus queue-fed message sequences.
module tb_cdc_in_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] src_data_i;
   logic [3:0]  src_valid_i;
   logic [3:0]  src_last_i;
   logic [3:0]  src_ready_o;
   logic [10:0] frame_i;
   logic        usb_configured_i;
   logic [7:0]  in_data_o;
   logic        in_valid_o;
   logic        in_ready_i;
   logic [3:0]  grant_o;
   logic        busy_o;

   cdc_in_arbiter #(.NUM_SRC(4), .MAX_BURST(16), .TIMEOUT_MS(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .src_data_i(src_data_i), .src_valid_i(src_valid_i),
      .src_last_i(src_last_i), .src_ready_o(src_ready_o), .frame_i(frame_i),
      .usb_configured_i(usb_configured_i), .in_data_o(in_data_o), .in_valid_o(in_valid_o),
      .in_ready_i(in_ready_i), .grant_o(grant_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        r;
      logic        c;
      logic [3:0]  eg;
      logic        ev;
      logic [7:0]  ed;
      logic [3:0]  es;
   } vec_t;

   vec_t tab [0:15];
   int   errors = 0;
   int   checks = 0;
   int   hs_err = 0;

   logic [8:0] mem [4][64];
   int hd [4];
   int tl [4];
   int log_src[$];
   int log_byte[$];
   int exp_src[$];
   int exp_byte[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int oh2idx(input logic [3:0] g);
      int r = -1;
      for (int k = 0; k < 4; k++) if (g[k]) r = k;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      src_valid_i = '0; src_last_i = '0; src_data_i = '0;
      in_ready_i = 1'b1; usb_configured_i = 1'b1; frame_i = '0;
      for (int k = 0; k < 4; k++) begin hd[k] = 0; tl[k] = 0; end
      log_src.delete(); log_byte.delete(); exp_src.delete(); exp_byte.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic push(input int s, input logic [7:0] b, input logic l);
      mem[s][tl[s]] = {l, b};
      tl[s]++;
   endtask

   task automatic expect_x(input int s, input int b);
      exp_src.push_back(s);
      exp_byte.push_back(b);
   endtask

   // One cycle of the source model: drive from queues, log the IN transfer, pop fired sources.
   task automatic cyc(input bit tog);
      logic [3:0] fire;
      @(negedge clk_i);
      if (tog) frame_i = frame_i ^ 11'd1;
      for (int k = 0; k < 4; k++) begin
         src_valid_i[k] = (hd[k] < tl[k]);
         src_data_i[k*8 +: 8] = (hd[k] < tl[k]) ? mem[k][hd[k]][7:0] : 8'h00;
         src_last_i[k] = (hd[k] < tl[k]) ? mem[k][hd[k]][8] : 1'b0;
      end
      #1;
      fire = src_valid_i & src_ready_o;
      if (in_valid_o && in_ready_i) begin
         log_src.push_back(oh2idx(grant_o));
         log_byte.push_back(int'(in_data_o));
      end
      if ((|fire) != (in_valid_o && in_ready_i)) hs_err++;
      @(posedge clk_i);
      for (int k = 0; k < 4; k++) if (fire[k]) hd[k]++;
   endtask

   task automatic compare_log(input string name);
      chk({name, " count"}, log_src.size(), exp_src.size());
      for (int i = 0; i < exp_src.size() && i < log_src.size(); i++) begin
         chk($sformatf("%s src[%0d]", name, i), log_src[i], exp_src[i]);
         chk($sformatf("%s byte[%0d]", name, i), log_byte[i], exp_byte[i]);
      end
   endtask

   initial begin
      //          v        l        d             r  c  eg       ev  ed     es
      tab[0]  = '{4'b0010, 4'b0000, 32'h0000_4100, 1, 1, 4'b0000, 0, 8'h00, 4'b0000};
      tab[1]  = '{4'b0010, 4'b0000, 32'h0000_4100, 1, 1, 4'b0010, 1, 8'h41, 4'b0010};
      tab[2]  = '{4'b0010, 4'b0000, 32'h0000_4200, 1, 1, 4'b0010, 1, 8'h42, 4'b0010};
      tab[3]  = '{4'b0010, 4'b0010, 32'h0000_4300, 1, 1, 4'b0010, 1, 8'h43, 4'b0010};
      tab[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 4'b0000, 0, 8'h00, 4'b0000};
      tab[5]  = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 0, 4'b0000, 0, 8'h00, 4'b0000};
      tab[6]  = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 0, 4'b0000, 0, 8'h00, 4'b0000};
      tab[7]  = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 1, 4'b0000, 0, 8'h00, 4'b0000};
      tab[8]  = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 1, 4'b0001, 1, 8'h11, 4'b0001};
      tab[9]  = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 0, 4'b0001, 0, 8'h11, 4'b0000};
      tab[10] = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 0, 4'b0000, 0, 8'h00, 4'b0000};
      tab[11] = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 1, 4'b0000, 0, 8'h00, 4'b0000};
      tab[12] = '{4'b1111, 4'b0000, 32'h4433_2211, 1, 1, 4'b0010, 1, 8'h22, 4'b0010};
      tab[13] = '{4'b1111, 4'b0000, 32'h4433_2211, 0, 1, 4'b0010, 1, 8'h22, 4'b0000};
      tab[14] = '{4'b1111, 4'b0010, 32'h4433_2211, 1, 1, 4'b0010, 1, 8'h22, 4'b0010};
      tab[15] = '{4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 4'b0000, 0, 8'h00, 4'b0000};

      do_reset();
      #1;
      chk("reset grant", grant_o, 4'b0000);
      chk("reset busy", busy_o, 1'b0);
      chk("reset in_valid", in_valid_o, 1'b0);

      for (int i = 0; i < 16; i++) begin
         if (i == 5) do_reset();
         @(negedge clk_i);
         src_valid_i = tab[i].v; src_last_i = tab[i].l; src_data_i = tab[i].d;
         in_ready_i = tab[i].r; usb_configured_i = tab[i].c;
         #1;
         chk($sformatf("vec%0d grant", i), grant_o, tab[i].eg);
         chk($sformatf("vec%0d busy", i), busy_o, |tab[i].eg);
         chk($sformatf("vec%0d in_valid", i), in_valid_o, tab[i].ev);
         chk($sformatf("vec%0d in_data", i), in_data_o, tab[i].ed);
         chk($sformatf("vec%0d src_ready", i), src_ready_o, tab[i].es);
      end

      // Two sources with 2-byte messages alternate and never interleave.
      do_reset();
      push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
      push(2, 8'hC0, 0); push(2, 8'hC1, 1); push(2, 8'hC2, 0); push(2, 8'hC3, 1);
      expect_x(0, 'hA0); expect_x(0, 'hA1); expect_x(2, 'hC0); expect_x(2, 'hC1);
      expect_x(0, 'hA2); expect_x(0, 'hA3); expect_x(2, 'hC2); expect_x(2, 'hC3);
      for (int i = 0; i < 20; i++) cyc(0);
      compare_log("rr");

      // Burst limit: source 3 streams 40 bytes, source 0 gets in after the first 16.
      do_reset();
      for (int i = 0; i < 40; i++) push(3, 8'(8'h80 + i), 0);
      cyc(0); cyc(0);
      push(0, 8'h10, 0); push(0, 8'h11, 1);
      for (int i = 0; i < 16; i++) expect_x(3, 'h80 + i);
      expect_x(0, 'h10); expect_x(0, 'h11);
      for (int i = 16; i < 40; i++) expect_x(3, 'h80 + i);
      for (int i = 0; i < 70; i++) cyc(0);
      compare_log("burst");
      chk("burst hold no beats", grant_o, 4'b1000);

      // Reset in the middle of a grant returns to idle at the next edge.
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("midreset grant", grant_o, 4'b0000);
      chk("midreset busy", busy_o, 1'b0);
      do_reset();

      // Idle timeout after three frame beats with the granted source silent.
      push(1, 8'h51, 0);
      push(2, 8'h61, 1);
      expect_x(1, 'h51); expect_x(2, 'h61);
      for (int i = 0; i < 3; i++) cyc(0);
      cyc(1); cyc(0); cyc(0); cyc(0);
      cyc(1); cyc(0); cyc(0); cyc(0);
      chk("timeout early hold", grant_o, 4'b0010);
      cyc(1);
      begin
         int n = 0;
         while (grant_o == 4'b0010 && n < 10) begin cyc(0); n++; end
         chk("timeout release", (grant_o != 4'b0010), 1'b1);
      end
      for (int i = 0; i < 6; i++) cyc(0);
      compare_log("timeout");

      chk("handshake consistency", hs_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
